// File: rtl/cache_pkg.sv
// Shared types and address helpers for the cache miss sequencer.
// Geometry: 8-way, 4 sets, 16-byte lines, 32-bit byte addresses.
package cache_pkg;

  localparam int TAG_W  = 26;
  localparam int IDX_W  = 2;
  localparam int OFF_W  = 4;
  localparam int LINE_W = 8 << OFF_W;
  localparam int LA_W   = TAG_W + IDX_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_WB,
    S_FETCH,
    S_WAIT,
    S_FILL,
    S_ACCESS,
    S_RESP
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [31:0] a
  );
    return a[OFF_W+IDX_W +: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(
    input logic [31:0] a
  );
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(
    input logic [31:0] a
  );
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [LA_W-1:0] line_addr(
    input logic [31:0] a
  );
    return a[OFF_W +: LA_W];
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// Line staging register shared by writeback and fill paths.
// Holds the victim line, then the fetched line.
module cache_line_buf
  import cache_pkg::*;
#(
  parameter int W = LINE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_vic,
  input  logic [W-1:0] vic_line,
  input  logic         load_mem,
  input  logic [W-1:0] mem_line,
  output logic [W-1:0] line
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line <= '0;
    end else if (load_vic) begin
      line <= vic_line;
    end else if (load_mem) begin
      line <= mem_line;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Request sequencer in front of an 8-way FIFO cache.
// Write-back, write-allocate; sole master of the cache port.
module cache_miss_ctrl #(
  parameter  int TAG_W  = 26,
  parameter  int IDX_W  = 2,
  parameter  int OFF_W  = 4,
  localparam int LINE_W = 8 << OFF_W,
  localparam int LA_W   = TAG_W + IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [31:0]       req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  output logic [7:0]        resp_rdata,
  output logic              cache_en,
  output logic              cache_rw,
  output logic              cache_fill,
  output logic [31:0]       cache_addr,
  output logic [7:0]        cache_wbyte,
  output logic [LINE_W-1:0] cache_line,
  input  logic              cache_hit,
  input  logic [7:0]        cache_rdata,
  input  logic              cache_vic_dirty,
  input  logic [TAG_W-1:0]  cache_vic_tag,
  input  logic [LINE_W-1:0] cache_vic_line,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [LA_W-1:0]   mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata
);

  import cache_pkg::*;

  state_t state_q;
  state_t state_d;

  logic [31:0]       addr_q;
  logic              rw_q;
  logic [7:0]        wbyte_q;
  logic [TAG_W-1:0]  vic_tag_q;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [LINE_W-1:0] line;
  logic              accept;
  logic              vic_load;
  logic              mem_load;

  assign tag = addr_q[OFF_W+IDX_W +: TAG_W];
  assign idx = addr_q[OFF_W +: IDX_W];

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign vic_load = (state_q == S_COMPARE) && !cache_hit;
  assign mem_load = (state_q == S_WAIT) && mem_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wbyte_q   <= '0;
      vic_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        rw_q    <= req_rw;
        wbyte_q <= req_wdata;
      end
      if (vic_load) begin
        vic_tag_q <= cache_vic_tag;
      end
    end
  end

  cache_line_buf #(
    .W (LINE_W)
  ) u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .load_vic (vic_load),
    .vic_line (cache_vic_line),
    .load_mem (mem_load),
    .mem_line (mem_rdata),
    .line     (line)
  );

  assign cache_addr  = addr_q;
  assign cache_wbyte = wbyte_q;
  assign cache_line  = line;
  assign mem_wdata   = line;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    cache_en   = 1'b0;
    cache_rw   = 1'b0;
    cache_fill = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    unique case (state_q)
      S_IDLE: begin
        // held low while reset is asserted
        req_ready = reset;
        if (req_valid) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_en = 1'b1;
        state_d  = S_COMPARE;
      end
      S_COMPARE: begin
        if (cache_hit) begin
          state_d = S_ACCESS;
        end else if (cache_vic_dirty) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag_q, idx};
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_valid = 1'b1;
        mem_addr  = {tag, idx};
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        cache_en   = 1'b1;
        cache_fill = 1'b1;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        cache_en = 1'b1;
        cache_rw = rw_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rw_q ? 8'h00 : cache_rdata;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench: cache and memory models around the sequencer,
// expectations from a flat byte memory plus per-set FIFO residency.
module tb_cache_miss_ctrl;
  import cache_pkg::*;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [31:0]       req_addr;
  logic [7:0]        req_wdata;
  logic              resp_valid;
  logic [7:0]        resp_rdata;
  logic              cache_en;
  logic              cache_rw;
  logic              cache_fill;
  logic [31:0]       cache_addr;
  logic [7:0]        cache_wbyte;
  logic [LINE_W-1:0] cache_line;
  logic              cache_hit;
  logic [7:0]        cache_rdata;
  logic              cache_vic_dirty;
  logic [TAG_W-1:0]  cache_vic_tag;
  logic [LINE_W-1:0] cache_vic_line;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [LA_W-1:0]   mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [LINE_W-1:0] mem_rdata;

  cache_miss_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .cache_en        (cache_en),
    .cache_rw        (cache_rw),
    .cache_fill      (cache_fill),
    .cache_addr      (cache_addr),
    .cache_wbyte     (cache_wbyte),
    .cache_line      (cache_line),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .cache_vic_dirty (cache_vic_dirty),
    .cache_vic_tag   (cache_vic_tag),
    .cache_vic_line  (cache_vic_line),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- cache model (stands in for cache_8way) ----------
  bit booted = 0;
  logic [TAG_W-1:0]  c_tag [4][8];
  logic              c_val [4][8];
  logic              c_dty [4][8];
  logic [LINE_W-1:0] c_dat [4][8];
  int                c_ptr [4];

  always @(posedge clk or negedge reset) begin : cache_model
    int s;
    int o;
    int hw;
    logic [TAG_W-1:0] t;
    if (!reset) begin
      if (!booted) begin
        for (int i = 0; i < 4; i++) begin
          c_ptr[i] <= 0;
          for (int j = 0; j < 8; j++) begin
            c_val[i][j] <= 1'b0;
            c_dty[i][j] <= 1'b0;
          end
        end
      end
    end else if (cache_en) begin
      s = int'(addr_idx(cache_addr));
      o = int'(addr_off(cache_addr));
      t = addr_tag(cache_addr);
      if (cache_fill) begin
        c_tag[s][c_ptr[s]] <= t;
        c_val[s][c_ptr[s]] <= 1'b1;
        c_dty[s][c_ptr[s]] <= 1'b0;
        c_dat[s][c_ptr[s]] <= cache_line;
        c_ptr[s] <= (c_ptr[s] + 1) % 8;
      end else begin
        hw = -1;
        for (int w = 0; w < 8; w++)
          if (c_val[s][w] && c_tag[s][w] == t) hw = w;
        cache_hit       <= (hw >= 0);
        cache_vic_dirty <= c_val[s][c_ptr[s]] && c_dty[s][c_ptr[s]];
        cache_vic_tag   <= c_tag[s][c_ptr[s]];
        cache_vic_line  <= c_dat[s][c_ptr[s]];
        if (hw >= 0) begin
          cache_rdata <= c_dat[s][hw][o*8 +: 8];
          if (cache_rw) begin
            c_dat[s][hw][o*8 +: 8] <= cache_wbyte;
            c_dty[s][hw] <= 1'b1;
          end
        end else begin
          cache_rdata <= 8'h00;
        end
      end
    end
  end

  // ---------------- memory model ------------------------------------
  logic [LINE_W-1:0] mem_store [logic [LA_W-1:0]];
  int n_wb = 0;
  int n_fe = 0;
  int n_ex = 0;
  int stall_knob = 0;
  int rv_knob = 1;
  logic [LA_W-1:0]   last_wb_addr = '0;
  logic [LINE_W-1:0] last_wb_line = '0;

  function automatic logic [7:0] init_byte(input logic [LA_W-1:0] la,
                                           input int off);
    return la[7:0] ^ la[15:8] ^ 8'(off * 29) ^ 8'h5A;
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [LA_W-1:0] la);
    logic [LINE_W-1:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int i = 0; i < LINE_W / 8; i++) l[i*8 +: 8] = init_byte(la, i);
    return l;
  endfunction

  initial begin : mem_resp
    int stall_left;
    int rv_wait;
    logic [LA_W-1:0] pend;
    stall_left = -1;
    rv_wait = 0;
    pend = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_wait > 0) begin
        rv_wait--;
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_line(pend);
        end
      end
      if (!reset) begin
        stall_left = -1;
      end else if (mem_valid) begin
        if (stall_left < 0) begin
          if (stall_knob < 0) stall_left = $urandom_range(0, 2);
          else if (!mem_we) stall_left = stall_knob;
          else stall_left = 0;
        end
        if (stall_left == 0) begin
          mem_ready = 1'b1;
          stall_left = -1;
          if (mem_we) begin
            mem_store[mem_addr] = mem_wdata;
            last_wb_addr = mem_addr;
            last_wb_line = mem_wdata;
            n_wb++;
          end else begin
            pend = mem_addr;
            n_fe++;
            rv_wait = (rv_knob > 0) ? rv_knob : $urandom_range(1, 3);
            n_ex += rv_wait - 1;
          end
        end else begin
          stall_left--;
          n_ex++;
        end
      end
    end
  end

  // ---------------- reference model and scoreboard ------------------
  typedef struct {
    logic [7:0] rdata;
    int wb;
    int fe;
    int base;
    int acc;
    int wb0;
    int fe0;
    int ex0;
  } exp_t;

  exp_t sbq[$];
  logic [7:0]      ref_byte [logic [31:0]];
  logic [LA_W-1:0] res_q[$];
  bit              res_dirty [logic [LA_W-1:0]];

  task automatic preset_line(input logic [LA_W-1:0] la,
                             input logic [LINE_W-1:0] l);
    mem_store[la] = l;
    for (int i = 0; i < LINE_W / 8; i++)
      ref_byte[{la, 4'(i)}] = l[i*8 +: 8];
  endtask

  task automatic issue(input logic rw, input logic [31:0] a,
                       input logic [7:0] wd, input bit commit);
    exp_t e;
    bit ok;
    int hitpos;
    int cnt;
    int first;
    logic [LA_W-1:0] la;
    ok = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_rw = rw;
    req_addr = a;
    req_wdata = wd;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    e.wb0 = n_wb;
    e.fe0 = n_fe;
    e.ex0 = n_ex;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!commit) return;
    la = line_addr(a);
    hitpos = -1;
    cnt = 0;
    first = -1;
    foreach (res_q[i]) begin
      if (res_q[i] == la) hitpos = i;
      if (res_q[i][IDX_W-1:0] == addr_idx(a)) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    e.wb = 0;
    e.fe = 0;
    if (hitpos < 0) begin
      e.fe = 1;
      if (cnt == 8) begin
        if (res_dirty[res_q[first]]) e.wb = 1;
        res_dirty.delete(res_q[first]);
        res_q.delete(first);
      end
      res_q.push_back(la);
      res_dirty[la] = 0;
    end
    e.base = (hitpos >= 0) ? 4 : (e.wb == 1 ? 8 : 7);
    if (rw) begin
      ref_byte[a] = wd;
      res_dirty[la] = 1;
      e.rdata = 8'h00;
    end else if (ref_byte.exists(a)) begin
      e.rdata = ref_byte[a];
    end else begin
      e.rdata = init_byte(la, int'(addr_off(a)));
    end
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && resp_valid) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: resp_valid 1, expected 0");
        end else begin
          e = sbq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("writebacks", n_wb - e.wb0, e.wb);
          chk("fetches", n_fe - e.fe0, e.fe);
          chk("latency", cyc - e.acc, e.base + n_ex - e.ex0);
        end
      end
    end
  end

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outstanding, expected 0", sbq.size());
    end
  endtask

  task automatic check_outputs_zero(input string tag_s);
    chk({tag_s, "_ctrl"},
        {req_ready, resp_valid, cache_en, cache_rw,
         cache_fill, mem_valid, mem_we}, 0);
    chk({tag_s, "_addr"}, {cache_addr, cache_wbyte, resp_rdata}, 0);
    chk({tag_s, "_memaddr"}, mem_addr, 0);
    chk({tag_s, "_lines"}, |{cache_line, mem_wdata}, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [LA_W-1:0] a0;
    logic [LINE_W-1:0] l;
    int nb;
    bit seen;
    reset = 1'b0;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    booted = 1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    // read hit after allocation
    l = '0;
    l[15*8 +: 8] = 8'h27;
    preset_line({26'd130, 2'd0}, l);
    issue(0, {26'd130, 2'd0, 4'd15}, 0, 1);
    issue(0, {26'd130, 2'd0, 4'd15}, 0, 1);
    // clean read miss on an all-FF line
    preset_line({26'd256, 2'd1}, {16{8'hFF}});
    issue(0, {26'd256, 2'd1, 4'd13}, 0, 1);
    drain();

    // dirty write miss: fill set 3 so dirty tag 112 is the victim
    issue(1, {26'd112, 2'd3, 4'd0}, 8'hDD, 1);
    for (int k = 0; k < 7; k++)
      issue(0, {26'(200 + k), 2'd3, 4'd0}, 0, 1);
    issue(1, {26'd257, 2'd3, 4'd0}, 8'hDD, 1);
    drain();
    chk("wb_addr", last_wb_addr, {26'd112, 2'd3});
    chk("wb_byte0", last_wb_line[7:0], 8'hDD);
    issue(0, {26'd257, 2'd3, 4'd0}, 0, 1);

    // write hit
    issue(0, {26'd117, 2'd2, 4'd4}, 0, 1);
    issue(1, {26'd117, 2'd2, 4'd4}, 8'h60, 1);
    issue(0, {26'd117, 2'd2, 4'd4}, 0, 1);
    drain();

    // fetch backpressure with stray requests
    stall_knob = 5;
    issue(0, {26'd777, 2'd2, 4'd9}, 0, 1);
    seen = 0;
    nb = 0;
    a0 = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (mem_valid && !mem_we) begin
        nb++;
        if (!seen) begin
          seen = 1;
          a0 = mem_addr;
        end else begin
          chk("bp_addr_stable", mem_addr, a0);
        end
        chk("bp_req_ready", req_ready, 0);
        req_valid = 1'b1;
        req_addr = $urandom;
      end else if (seen) begin
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    chk("bp_fetch_addr", a0, {26'd777, 2'd2});
    chk("bp_cycles", nb, 6);
    drain();
    stall_knob = 0;

    // reset while waiting for fetch data
    rv_knob = 8;
    nb = n_fe;
    issue(0, {26'd999, 2'd0, 4'd3}, 0, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (n_fe != nb) break;
    end
    chk("abort_fetch_seen", n_fe - nb, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rvalid) begin
        seen = 1;
        break;
      end
    end
    chk("late_rvalid_seen", seen, 1);
    @(negedge clk);
    chk("late_rvalid_ignored", {req_ready, mem_valid, cache_en}, 3'b100);
    rv_knob = 1;
    issue(0, {26'd999, 2'd0, 4'd3}, 0, 1);
    drain();

    // randomized traffic, small tag pool per set to force evictions
    stall_knob = -1;
    rv_knob = -1;
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)),
            {26'(300 + 5 * $urandom_range(0, 11)),
             2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15))},
            8'($urandom), 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Request sequencer that sits in front of `cache_8way` (8-way, 4 sets, 16-byte lines, FIFO replacement). It accepts one byte read or write at a time and probes the cache. On a miss it writes back the dirty FIFO victim, fetches the line from memory, fills it, then replays the access. Policy is write-back, write-allocate. It drives the cache's `cycle_en` strobe and all cache address/data inputs, so the cache has no other master.

## Interface
- `TAG_W`, default 26: tag width.
- `IDX_W`, default 2: set index width.
- `OFF_W`, default 4: byte offset width; `LINE_W = 8 << OFF_W` (128).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  high only in IDLE; handshake = valid & ready.
- `req_rw`  in  1  0 = read, 1 = write.
- `req_addr`  in  32  {tag, index, offset}.
- `req_wdata`  in  8  write byte.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  8  read byte (0 for writes), valid with `resp_valid`.
- `cache_en`  out  1  cache `cycle_en` strobe.
- `cache_rw`  out  1  byte-write enable to cache.
- `cache_fill`  out  1  install `cache_line` into the FIFO victim way, clean.
- `cache_addr`  out  32  latched request address.
- `cache_wbyte`  out  8  latched write byte.
- `cache_line`  out  LINE_W  fill line.
- `cache_hit`  in  1  probe result, valid the cycle after `cache_en`.
- `cache_rdata`  in  8  read byte, valid the cycle after `cache_en`.
- `cache_vic_dirty`  in  1  FIFO victim of the probed set is valid and dirty.
- `cache_vic_tag`  in  TAG_W  victim tag.
- `cache_vic_line`  in  LINE_W  victim data.
- `mem_valid`  out  1  memory command.
- `mem_ready`  in  1  command accepted.
- `mem_we`  out  1  1 = writeback, 0 = line fetch.
- `mem_addr`  out  TAG_W+IDX_W  line address {tag, index}.
- `mem_wdata`  out  LINE_W  writeback line.
- `mem_rvalid`  in  1  fetch data returned.
- `mem_rdata`  in  LINE_W  fetched line.

## Operation
- State machine:
  - IDLE: `req_ready` = 1. On handshake, latch addr/rw/wdata and go to LOOKUP.
  - LOOKUP: `cache_en` = 1, `cache_rw` = 0 (probe). Go to COMPARE.
  - COMPARE: on hit go to ACCESS. On miss, latch `cache_vic_tag`/`cache_vic_line`; if `cache_vic_dirty` go to WB, else go to FETCH.
  - WB: `mem_valid` = 1, `mem_we` = 1, `mem_addr` = {vic_tag, index}. On `mem_ready` go to FETCH.
  - FETCH: `mem_valid` = 1, `mem_we` = 0, `mem_addr` = {tag, index}. On `mem_ready` go to WAIT.
  - WAIT: on `mem_rvalid`, latch `mem_rdata` and go to FILL.
  - FILL: `cache_en` = 1, `cache_fill` = 1. Go to ACCESS.
  - ACCESS: `cache_en` = 1, `cache_rw` = latched rw. Go to RESP.
  - RESP: `resp_valid` = 1; `resp_rdata` = `cache_rdata` for a read, 0 for a write. Go to IDLE.
- Outputs are Moore decodes of state plus latched registers.
- `mem_valid`, `mem_addr` and `mem_wdata` stay stable until `mem_ready`.
- `req_valid` outside IDLE is ignored. `mem_rvalid` outside WAIT is ignored.
- Exactly one writeback, at most, and one fetch per miss. Hits generate no memory traffic.

## Timing
- Reset asserted: state = IDLE, every output 0 (including `req_ready`), latched registers cleared.
- First cycle after release: `req_ready` = 1.
- Reset mid-operation: immediate abort. The in-flight memory transaction is abandoned; the memory side is reset together with this block.
- Latency, counted in cycles after the accept edge, to `resp_valid`:
  - hit: 4th cycle.
  - clean miss with `mem_ready` immediate and `mem_rvalid` one cycle later: 7th cycle.
  - dirty miss under the same memory timing: 8th cycle.
  - each memory stall cycle adds one.
- Back-to-back: the next request can be accepted in the cycle after RESP.

## Structure
- Shared package `cache_pkg` holds:
  - `TAG_W`, `IDX_W`, `OFF_W`, `LINE_W`;
  - the state enum;
  - address-slice helpers: tag, index, offset, line address.
- One sub-module, `cache_line_buf`: a LINE_W register loaded from the victim in COMPARE or from `mem_rdata` in WAIT. It drives both `mem_wdata` and `cache_line`.

## Test plan
- Read hit: set 0 holds tag 130 with byte 15 = 8'h27; read {130, 0, 15} -> `resp_rdata` = 8'h27 in the 4th cycle, `mem_valid` never asserted.
- Clean read miss: read {256, 1, 13}, victim clean; memory returns all-FF one cycle after ready -> single fetch at addr {256, 1}, fill line all-FF, `resp_rdata` = 8'hFF in the 7th cycle.
- Dirty write miss: write 8'hDD to {257, 3, 0}, victim tag 112 dirty -> writeback at {112, 3} with the victim line, then fetch at {257, 3}, fill, byte write. A subsequent read of {257, 3, 0} hits and returns 8'hDD.
- Write hit: write 8'h60 to {117, 2, 4} -> no memory traffic; readback returns 8'h60.
- Backpressure: `mem_ready` held low 5 cycles in FETCH -> `mem_valid`/`mem_addr` stable throughout, `req_ready` = 0, stray `req_valid` pulses ignored, response arrives 5 cycles later.
- Reset asserted in WAIT -> outputs 0 immediately, IDLE after release. A late `mem_rvalid` is ignored; the next request completes normally.
